piso_shift_tx: RTL and testbench

- Parallel-in serial-out transmitter for the sequential_logic library.
- Accepts a WIDTH-bit word over a valid/ready load handshake and shifts it out one bit per accepted serial beat, with backpressure.
- Pairs with the library's serial-in capture flops/shift registers as the transmitting end of a simple bit-serial link.
- Supports gapless back-to-back words.

---
 rtl/piso_shift_tx.sv | 75 +++++++
 tb/tb_piso_shift_tx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in serial-out transmitter.
// A word is taken over a valid/ready handshake and shifted out one bit per
// accepted beat (sout_valid && sout_ready). A new word may be loaded on the
// final beat of the current one, so consecutive words leave with no idle gap.
module piso_shift_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             sout_last,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             beat;
  logic             load;

  // Outputs are decoded from registered state only; load_valid/load_data
  // never reach an output combinationally.
  assign sout_valid = (state_q == SHIFT);
  assign busy       = sout_valid;
  assign sout_last  = sout_valid && (cnt_q == LAST);
  assign sout       = sout_valid && (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);

  // Idle accepts whenever out of reset; in SHIFT only the final beat frees
  // the register, which is what makes back-to-back words gapless.
  assign load_ready = (state_q == IDLE) ? rst : (sout_last && sout_ready);

  assign beat = sout_valid && sout_ready;
  assign load = load_valid && load_ready;

  // Shift toward the output end so the current bit always sits at the edge.
  always_comb begin
    shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
    cnt_d   = cnt_q + CW'(1);
  end

  // FSM: IDLE waits for a word, SHIFT sends it; a load wins over the final beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      state_q <= SHIFT;
      shreg_q <= load_data;
      cnt_q   <= '0;
    end else if (beat) begin
      shreg_q <= shreg_d;
      if (sout_last) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        cnt_q   <= cnt_d;
      end
    end
  end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: an MSB-first and an LSB-first instance share all
// stimulus and are compared every cycle against a word/bits-remaining model.
module tb_piso_shift_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       sout_ready = 1'b0;

  logic ready_m, sout_m, valid_m, last_m, busy_m;
  logic ready_l, sout_l, valid_l, last_l, busy_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(ready_m),
    .load_data(load_data), .sout(sout_m), .sout_valid(valid_m),
    .sout_ready(sout_ready), .sout_last(last_m), .busy(busy_m));

  piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(ready_l),
    .load_data(load_data), .sout(sout_l), .sout_valid(valid_l),
    .sout_ready(sout_ready), .sout_last(last_l), .busy(busy_l));

  // Reference model: the word in flight and how many of its bits remain.
  int         rem = 0;
  logic [7:0] mw  = 8'h00;
  logic       er, ev, el, esm, esl;

  assign er  = rst && ((rem == 0) || (rem == 1 && sout_ready));
  assign ev  = (rem != 0);
  assign el  = (rem == 1);
  assign esm = ev ? mw[rem-1] : 1'b0;   // MSB first: bit 7,6,..0
  assign esl = ev ? mw[8-rem] : 1'b0;   // LSB first: bit 0,1,..7

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem <= 0;
      mw  <= 8'h00;
    end else if (load_valid && er) begin
      rem <= 8;
      mw  <= load_data;
    end else if (rem != 0 && sout_ready) begin
      rem <= rem - 1;
    end
  end

  logic [9:0] obs, expv;
  assign obs  = {sout_m, sout_l, valid_m, valid_l, last_m, last_l,
                 ready_m, ready_l, busy_m, busy_l};
  assign expv = {esm, esl, ev, ev, el, el, er, er, ev, ev};

  // Beats collected as shifted-in words, for whole-sequence checks.
  logic [31:0] gm, gl;
  int          nb;

  task automatic drive(input logic lv, input logic [7:0] d, input logic sr);
    @(negedge clk);
    load_valid = lv;
    load_data  = d;
    sout_ready = sr;
    #1;
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  task automatic test_reset();
    #2;
    checks++;
    if (obs !== 10'b0) begin
      errors++;
      $display("FAIL reset_hold obs=%b exp=%b", obs, 10'b0);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== 10'b0000001100) begin
      errors++;
      $display("FAIL reset_release obs=%b exp=%b", obs, 10'b0000001100);
    end
  endtask

  task automatic test_basic(input logic [7:0] w);
    gm = '0; gl = '0; nb = 0;
    drive(1'b1, w, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      drive(1'b0, 8'h00, 1'b1);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL basic_%h cyc=%0d obs=%b exp=%b", w, c, obs, expv);
      end
      if (valid_m && sout_ready) begin
        gm = {gm[30:0], sout_m}; gl = {gl[30:0], sout_l}; nb++;
      end
    end
    checks++;
    if (nb !== 8 || gm[7:0] !== w || gl[7:0] !== rev8(w)) begin
      errors++;
      $display("FAIL basic_seq_%h beats=%0d msb=%h lsb=%h exp 8 %h %h",
               w, nb, gm[7:0], gl[7:0], w, rev8(w));
    end
  endtask

  task automatic test_backpressure();
    gm = '0; gl = '0; nb = 0;
    drive(1'b1, 8'hF0, 1'b1);
    for (int c = 1; c <= 14; c++) begin
      drive(1'b0, 8'h00, !(c >= 3 && c <= 5));
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL backpressure cyc=%0d obs=%b exp=%b", c, obs, expv);
      end
      if (valid_m && sout_ready) begin
        gm = {gm[30:0], sout_m}; gl = {gl[30:0], sout_l}; nb++;
      end
    end
    checks++;
    if (nb !== 8 || gm[7:0] !== 8'hF0 || gl[7:0] !== 8'h0F) begin
      errors++;
      $display("FAIL backpressure_seq beats=%0d msb=%h lsb=%h exp 8 f0 0f",
               nb, gm[7:0], gl[7:0]);
    end
  endtask

  task automatic test_back_to_back();
    int gaps, pulses;
    gm = '0; nb = 0; gaps = 0; pulses = 0;
    drive(1'b1, 8'h3C, 1'b1);
    for (int c = 1; c <= 17; c++) begin
      drive(c <= 8, 8'hC3, 1'b1);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d obs=%b exp=%b", c, obs, expv);
      end
      if (c <= 16 && !valid_m) gaps++;
      if (c <= 16 && ready_m) pulses++;
      if (valid_m && sout_ready) begin
        gm = {gm[30:0], sout_m}; nb++;
      end
    end
    checks++;
    if (nb !== 16 || gm[15:0] !== 16'h3CC3 || gaps !== 0 || pulses !== 2) begin
      errors++;
      $display("FAIL back_to_back_seq beats=%0d bits=%h gaps=%0d pulses=%0d exp 16 3cc3 0 2",
               nb, gm[15:0], gaps, pulses);
    end
  endtask

  task automatic test_ignored_load();
    gm = '0; nb = 0;
    drive(1'b1, 8'h00, 1'b1);
    for (int c = 1; c <= 18; c++) begin
      drive((c >= 4 && c <= 8), (c >= 4) ? 8'hFF : 8'h00, 1'b1);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL ignored_load cyc=%0d obs=%b exp=%b", c, obs, expv);
      end
      if (valid_m && sout_ready) begin
        gm = {gm[30:0], sout_m}; nb++;
      end
    end
    checks++;
    if (nb !== 16 || gm[15:0] !== 16'h00FF) begin
      errors++;
      $display("FAIL ignored_load_seq beats=%0d bits=%h exp 16 00ff", nb, gm[15:0]);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 8'hAA, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      drive(1'b0, 8'h00, 1'b1);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL async_pre cyc=%0d obs=%b exp=%b", c, obs, expv);
      end
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (obs !== 10'b0) begin
      errors++;
      $display("FAIL async_reset obs=%b exp=%b", obs, 10'b0);
    end
    @(negedge clk);
    rst = 1'b1;
    gm = '0; gl = '0; nb = 0;
    drive(1'b1, 8'h81, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      drive(1'b0, 8'h00, 1'b1);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL async_post cyc=%0d obs=%b exp=%b", c, obs, expv);
      end
      if (valid_m && sout_ready) begin
        gm = {gm[30:0], sout_m}; gl = {gl[30:0], sout_l}; nb++;
      end
    end
    checks++;
    if (nb !== 8 || gm[7:0] !== 8'h81 || gl[7:0] !== 8'h81) begin
      errors++;
      $display("FAIL async_post_seq beats=%0d msb=%h lsb=%h exp 8 81 81",
               nb, gm[7:0], gl[7:0]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL random cyc=%0d obs=%b exp=%b", c, obs, expv);
      end
    end
    drive(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic(8'hA5);
    test_basic(8'h01);
    test_basic(8'h6D);
    test_backpressure();
    test_back_to_back();
    test_ignored_load();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
